// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - sweeps a 2-input gate's four input vectors and checks it against a golden function
// Optional per-vector failure map output enabled by defining GATE_CHK_FAILMAP_EN.
module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ROUNDS        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       func_sel,
    output logic             stim_a,
    output logic             stim_b,
    input  logic             dut_result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_vec
`ifdef GATE_CHK_FAILMAP_EN
    ,
    output logic [3:0]       fail_map
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYCLES);
    localparam logic [7:0]       ROUND_LAST  = 8'(ROUNDS);

    state_t           state;
    logic [1:0]       func_q;
    logic [1:0]       vec;
    logic [7:0]       round;
    logic [7:0]       settle_cnt;
    logic             golden;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    always_comb begin
        golden = 1'b0;
        case (func_q)
            2'b00: golden = stim_a & stim_b;
            2'b01: golden = stim_a | stim_b;
            2'b10: golden = stim_a ^ stim_b;
            2'b11: golden = ~(stim_a & stim_b);
            default: golden = 1'b0;
        endcase
        mismatch = (dut_result != golden);
        err_next = err_count;
        if (mismatch && err_count != ERR_MAX) begin
            err_next = err_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            func_q         <= 2'b00;
            vec            <= 2'b00;
            round          <= 8'd0;
            settle_cnt     <= 8'd0;
            stim_a         <= 1'b0;
            stim_b         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= 2'b00;
`ifdef GATE_CHK_FAILMAP_EN
            fail_map       <= 4'b0000;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        func_q         <= func_sel;
                        err_count      <= '0;
                        pass           <= 1'b0;
                        first_fail_vec <= 2'b00;
`ifdef GATE_CHK_FAILMAP_EN
                        fail_map       <= 4'b0000;
`endif
                        vec            <= 2'b00;
                        round          <= 8'd1;
                        busy           <= 1'b1;
                        state          <= S_DRIVE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DRIVE: begin
                    {stim_a, stim_b} <= vec;
                    settle_cnt       <= SETTLE_INIT;
                    state            <= (SETTLE_INIT == 8'd0) ? S_SAMPLE : S_SETTLE;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt - 8'd1;
                    if (settle_cnt == 8'd1) begin
                        state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    err_count <= err_next;
                    // a saturated count never returns to zero, so zero means no earlier mismatch
                    if (mismatch && err_count == '0) begin
                        first_fail_vec <= {stim_a, stim_b};
                    end
`ifdef GATE_CHK_FAILMAP_EN
                    if (mismatch) begin
                        fail_map[{stim_a, stim_b}] <= 1'b1;
                    end
`endif
                    vec <= vec + 2'd1;
                    if (vec == 2'd3 && round == ROUND_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= S_DONE;
                    end else begin
                        if (vec == 2'd3) begin
                            round <= round + 8'd1;
                        end
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
